// File: rtl/sram_confreg_responder.sv
// sram_confreg_responder
// Responder for the core's data SRAM port. Each access is decoded either to a
// local word-addressed RAM or to a small configuration region that holds the
// LED register, synchronised switches, a free-running timer and a sticky
// compare interrupt. Read data is registered and appears the cycle after the
// request.
module sram_confreg_responder #(
   parameter int          RAM_AW    = 16,
   parameter logic [15:0] CONF_BASE = 16'hBFAF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        data_sram_en,
   input  logic [3:0]  data_sram_wen,
   input  logic [31:0] data_sram_addr,
   input  logic [31:0] data_sram_wdata,
   output logic [31:0] data_sram_rdata,
   output logic [15:0] led,
   input  logic [7:0]  switch,
   output logic        timer_int
);

   localparam int          DEPTH      = 2 ** RAM_AW;
   localparam logic [15:0] OFF_LED    = 16'hF000;
   localparam logic [15:0] OFF_SWITCH = 16'hF004;
   localparam logic [15:0] OFF_TIMER  = 16'hF008;
   localparam logic [15:0] OFF_CMP    = 16'hF00C;
   localparam logic [15:0] OFF_STATUS = 16'hF010;

   // Storage
   logic [31:0] r_mem [DEPTH];
   logic [31:0] r_rdata;
   logic [15:0] r_led;
   logic [31:0] r_timer;
   logic [31:0] r_cmp;
   logic        r_pending;
   logic [7:0]  r_sw_meta;
   logic [7:0]  r_sw_sync;

   // Decode and datapath helpers
   logic              w_conf;
   logic              w_rd;
   logic              w_wr;
   logic              w_wr_ram;
   logic              w_wr_conf;
   logic [RAM_AW-1:0] w_idx;
   logic [15:0]       w_off;
   logic [31:0]       w_mask;
   logic [31:0]       w_conf_rdata;
   logic [15:0]       w_led_merged;
   logic [31:0]       w_timer_merged;
   logic [31:0]       w_cmp_merged;
   logic              w_pend_set;
   logic              w_pend_clr;

   assign w_conf    = (data_sram_addr[31:16] == CONF_BASE);
   assign w_rd      = data_sram_en && (data_sram_wen == 4'b0000);
   assign w_wr      = data_sram_en && (data_sram_wen != 4'b0000);
   assign w_wr_ram  = w_wr && !w_conf;
   assign w_wr_conf = w_wr && w_conf;
   assign w_idx     = data_sram_addr[RAM_AW+1:2];
   assign w_off     = data_sram_addr[15:0];

   // Expand the byte enables into a bit mask used for all config merges.
   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_mask
         assign w_mask[8*gi +: 8] = {8{data_sram_wen[gi]}};
      end
   endgenerate

   assign w_led_merged   = (r_led & ~w_mask[15:0]) | (data_sram_wdata[15:0] & w_mask[15:0]);
   assign w_timer_merged = (r_timer & ~w_mask) | (data_sram_wdata & w_mask);
   assign w_cmp_merged   = (r_cmp & ~w_mask) | (data_sram_wdata & w_mask);

   // Compare hit uses the pre-edge timer; a zero compare value never fires.
   assign w_pend_set = (r_timer == r_cmp) && (r_cmp != 32'd0);
   assign w_pend_clr = w_wr_conf && (w_off == OFF_STATUS) &&
                       data_sram_wen[0] && data_sram_wdata[0];

   // Config read mux: pre-edge register values, unmapped offsets read zero.
   always_comb begin
      w_conf_rdata = 32'd0;
      case (w_off)
         OFF_LED:    w_conf_rdata = {16'd0, r_led};
         OFF_SWITCH: w_conf_rdata = {24'd0, r_sw_sync};
         OFF_TIMER:  w_conf_rdata = r_timer;
         OFF_CMP:    w_conf_rdata = r_cmp;
         OFF_STATUS: w_conf_rdata = {31'd0, r_pending};
         default:    w_conf_rdata = 32'd0;
      endcase
   end

   // RAM byte-lane writes; contents are deliberately not reset.
   always_ff @(posedge clk) begin
      if (w_wr_ram) begin
         for (int b = 0; b < 4; b++) begin
            if (data_sram_wen[b]) begin
               r_mem[w_idx][8*b +: 8] <= data_sram_wdata[8*b +: 8];
            end
         end
      end
   end

   // Read data register: loaded only on reads, cleared by reset.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_rdata <= 32'd0;
      end else if (w_rd) begin
         r_rdata <= w_conf ? w_conf_rdata : r_mem[w_idx];
      end
   end

   // Config registers: LED, timer (load beats increment), compare, sticky pending.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_led     <= 16'd0;
         r_timer   <= 32'd0;
         r_cmp     <= 32'd0;
         r_pending <= 1'b0;
      end else begin
         if (w_wr_conf && (w_off == OFF_LED)) begin
            r_led <= w_led_merged;
         end
         if (w_wr_conf && (w_off == OFF_TIMER)) begin
            r_timer <= w_timer_merged;
         end else begin
            r_timer <= r_timer + 32'd1;
         end
         if (w_wr_conf && (w_off == OFF_CMP)) begin
            r_cmp <= w_cmp_merged;
         end
         r_pending <= w_pend_set | (r_pending & ~w_pend_clr);
      end
   end

   // Two-flop synchroniser for the asynchronous switch inputs.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_sw_meta <= 8'd0;
         r_sw_sync <= 8'd0;
      end else begin
         r_sw_meta <= switch;
         r_sw_sync <= r_sw_meta;
      end
   end

   assign data_sram_rdata = r_rdata;
   assign led             = r_led;
   assign timer_int       = r_pending;

endmodule

// File: tb/tb_sram_confreg_responder.sv
// Testbench for sram_confreg_responder: directed scenarios followed by random
// traffic. A driver pushes expected read data into a scoreboard queue; a
// monitor pops it when the read response is due and also tracks led/timer_int.
module tb_sram_confreg_responder;

   logic        clk = 1'b0;
   logic        rst;
   logic        en;
   logic [3:0]  wen;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic [31:0] rdata;
   logic [15:0] led;
   logic [7:0]  sw;
   logic        tint;

   always #5 clk = ~clk;

   sram_confreg_responder #(.RAM_AW(16), .CONF_BASE(16'hBFAF)) dut (
      .clk             (clk),
      .rst             (rst),
      .data_sram_en    (en),
      .data_sram_wen   (wen),
      .data_sram_addr  (addr),
      .data_sram_wdata (wdata),
      .data_sram_rdata (rdata),
      .led             (led),
      .switch          (sw),
      .timer_int       (tint)
   );

   typedef struct {
      logic [31:0] a;
      logic [31:0] exp;
   } rd_t;

   rd_t         sb_q[$];
   int          n_chk = 0;
   int          n_fail = 0;
   int          cyc = 0;
   int          last_rst = -1000;
   bit          started = 0;
   logic [7:0]  sw_val = 8'h00;

   // Reference model state
   logic [31:0] m_mem [int];
   logic [7:0]  sw_hist [int];
   logic [15:0] m_led = 16'h0;
   logic [31:0] m_cmp = 32'h0;
   logic        m_pending = 1'b0;
   logic [31:0] t_base = 32'h0;
   int          t_cyc = 0;

   function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endfunction

   function automatic logic [31:0] mrg(logic [31:0] old_v, logic [31:0] new_v, logic [3:0] be);
      logic [31:0] m;
      m = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
      return (old_v & ~m) | (new_v & m);
   endfunction

   // Timer is "value loaded" plus "cycles elapsed since the load".
   function automatic logic [31:0] timer_at(int c);
      return t_base + 32'(c - t_cyc);
   endfunction

   function automatic bit is_conf(logic [31:0] a);
      return a[31:16] == 16'hBFAF;
   endfunction

   function automatic int ram_key(logic [31:0] a);
      return int'((a >> 2) & 32'h0000FFFF);
   endfunction

   // Expected read data for a request issued in the current cycle.
   function automatic logic [31:0] model_read(logic [31:0] a);
      logic [15:0] off;
      off = a[15:0];
      if (!is_conf(a)) return m_mem.exists(ram_key(a)) ? m_mem[ram_key(a)] : 32'hx;
      case (off)
         16'hF000: return {16'h0, m_led};
         16'hF004: return (cyc - 2 <= last_rst) ? 32'h0 : {24'h0, sw_hist[cyc-2]};
         16'hF008: return timer_at(cyc);
         16'hF00C: return m_cmp;
         16'hF010: return {31'h0, m_pending};
         default:  return 32'h0;
      endcase
   endfunction

   // Apply the effect of one clock edge given that cycle's inputs.
   function automatic void model_edge(logic r, logic e, logic [3:0] w, logic [31:0] a, logic [31:0] d);
      logic        set_p;
      logic        clr_p;
      logic [31:0] tmp;
      if (!r) begin
         m_led = 16'h0; m_cmp = 32'h0; m_pending = 1'b0;
         t_base = 32'h0; t_cyc = cyc + 1; last_rst = cyc; started = 1;
         return;
      end
      set_p = (timer_at(cyc) == m_cmp) && (m_cmp != 32'h0);
      clr_p = 1'b0;
      if (e && w != 4'h0) begin
         if (is_conf(a)) begin
            case (a[15:0])
               16'hF000: begin tmp = mrg({16'h0, m_led}, d, w); m_led = tmp[15:0]; end
               16'hF008: begin t_base = mrg(timer_at(cyc), d, w); t_cyc = cyc + 1; end
               16'hF00C: m_cmp = mrg(m_cmp, d, w);
               16'hF010: clr_p = w[0] & d[0];
               default: ;
            endcase
         end else begin
            tmp = m_mem.exists(ram_key(a)) ? m_mem[ram_key(a)] : 32'h0;
            m_mem[ram_key(a)] = mrg(tmp, d, w);
         end
      end
      m_pending = set_p | (m_pending & ~clr_p);
   endfunction

   task automatic step(input logic r, input logic e, input logic [3:0] w, input logic [31:0] a,
                       input logic [31:0] d, input bit use_exp, input logic [31:0] exp_v);
      rd_t t;
      rst = r; en = e; wen = w; addr = a; wdata = d; sw = sw_val;
      sw_hist[cyc] = sw_val;
      if (r && e && w == 4'h0) begin
         t.a = a;
         t.exp = use_exp ? exp_v : model_read(a);
         sb_q.push_back(t);
      end
      @(posedge clk);
      model_edge(r, e, w, a, d);
      cyc++;
      #1;
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] w);
      step(1'b1, 1'b1, w, a, d, 1'b0, 32'h0);
   endtask
   task automatic rd(input logic [31:0] a);
      step(1'b1, 1'b1, 4'h0, a, 32'h0, 1'b0, 32'h0);
   endtask
   task automatic rdx(input logic [31:0] a, input logic [31:0] exp_v);
      step(1'b1, 1'b1, 4'h0, a, 32'h0, 1'b1, exp_v);
   endtask
   task automatic idle();
      step(1'b1, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 32'h0);
   endtask

   function automatic logic [31:0] ram_addr(int idx);
      logic [31:0] a;
      a = $urandom;
      a[17:2] = idx[15:0];
      if (a[31:16] == 16'hBFAF) a[31] = 1'b0;
      return a;
   endfunction

   // Monitor: pops the scoreboard when a read response is due.
   bit          pend_rd = 0;
   bit          pend_rst = 0;
   logic [31:0] hold_v = 32'h0;
   int          n_rd = 0;
   always @(negedge clk) begin
      rd_t t;
      if (started) begin
         if (pend_rst) begin
            hold_v = 32'h0;
            chk("rdata_after_rst", rdata, 32'h0);
         end else if (pend_rd) begin
            if (sb_q.size() == 0) begin
               n_chk++; n_fail++;
               $display("FAIL sb_underflow: got rdata %h expected a queued entry", rdata);
            end else begin
               t = sb_q.pop_front();
               n_rd++;
               $display("rd %0d addr=%h rdata=%h exp=%h", n_rd, t.a, rdata, t.exp);
               chk("rdata", rdata, t.exp);
               hold_v = t.exp;
            end
         end else begin
            chk("rdata_hold", rdata, hold_v);
         end
         chk("led", {16'h0, led}, {16'h0, m_led});
         chk("timer_int", {31'h0, tint}, {31'h0, m_pending});
      end
      pend_rd  = en && (wen == 4'h0) && rst;
      pend_rst = !rst;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   int pool[8] = '{0, 1, 5, 100, 4095, 32768, 65535, 12345};
   logic [15:0] offs[7] = '{16'hF000, 16'hF004, 16'hF008, 16'hF00C, 16'hF010, 16'hF0FC, 16'h1234};

   initial begin
      // Reset
      step(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 32'h0);
      step(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 32'h0);
      chk("reset_led", {16'h0, led}, 32'h0);
      chk("reset_tint", {31'h0, tint}, 32'h0);
      chk("reset_rdata", rdata, 32'h0);

      // RAM full and partial writes, aliasing
      wr(32'h0000_0010, 32'hDEADBEEF, 4'hF);
      rdx(32'h0000_0010, 32'hDEADBEEF);
      wr(32'h0000_0010, 32'h11223344, 4'b0101);
      rdx(32'h0000_0010, 32'hDE22BE44);
      wr(32'h0000_0010, 32'hAA000000, 4'b1000);
      rdx(32'h0000_0010, 32'hAA22BE44);
      rdx(32'h0004_0010, 32'hAA22BE44);

      // LED and switches
      wr(32'hBFAF_F000, 32'h0001A5A5, 4'hF);
      chk("led_a5a5", {16'h0, led}, 32'h0000A5A5);
      rdx(32'hBFAF_F000, 32'h0000A5A5);
      sw_val = 8'h3C;
      idle(); idle(); idle();
      rdx(32'hBFAF_F004, 32'h0000003C);
      sw_val = 8'h81;
      idle();
      rdx(32'hBFAF_F004, 32'h0000003C);
      rdx(32'hBFAF_F004, 32'h00000081);

      // Timer compare interrupt
      wr(32'hBFAF_F00C, 32'd20, 4'hF);
      wr(32'hBFAF_F008, 32'd10, 4'hF);
      repeat (10) idle();
      chk("tint_before", {31'h0, tint}, 32'h0);
      idle();
      chk("tint_rise", {31'h0, tint}, 32'h1);
      repeat (3) idle();
      chk("tint_sticky", {31'h0, tint}, 32'h1);
      wr(32'hBFAF_F010, 32'h0, 4'hF);
      chk("tint_wr0", {31'h0, tint}, 32'h1);
      wr(32'hBFAF_F010, 32'h1, 4'b0010);
      chk("tint_nobe", {31'h0, tint}, 32'h1);
      rdx(32'hBFAF_F010, 32'h1);
      wr(32'hBFAF_F010, 32'h1, 4'h1);
      chk("tint_clr", {31'h0, tint}, 32'h0);
      rdx(32'hBFAF_F010, 32'h0);
      rdx(32'hBFAF_F00C, 32'd20);

      // cmp=0 never fires, timer wrap
      wr(32'hBFAF_F00C, 32'h0, 4'hF);
      wr(32'hBFAF_F008, 32'hFFFFFFFE, 4'hF);
      rdx(32'hBFAF_F008, 32'hFFFFFFFE);
      rdx(32'hBFAF_F008, 32'hFFFFFFFF);
      rdx(32'hBFAF_F008, 32'h00000000);
      repeat (3) idle();
      chk("tint_cmp0", {31'h0, tint}, 32'h0);

      // Unmapped offset
      rdx(32'hBFAF_F0FC, 32'h0);
      wr(32'hBFAF_F0FC, 32'hFFFFFFFF, 4'hF);
      rdx(32'hBFAF_F000, 32'h0000A5A5);
      rdx(32'hBFAF_F00C, 32'h0);

      // Reset mid-operation, config write during reset ignored
      wr(32'h0000_0040, 32'h12345678, 4'hF);
      wr(32'hBFAF_F000, 32'h0000FFFF, 4'hF);
      rdx(32'h0000_0040, 32'h12345678);
      chk("pre_rst_rdata", rdata, 32'h12345678);
      chk("pre_rst_led", {16'h0, led}, 32'h0000FFFF);
      step(1'b0, 1'b1, 4'hF, 32'hBFAF_F000, 32'h00001234, 1'b0, 32'h0);
      chk("rst_rdata", rdata, 32'h0);
      chk("rst_led", {16'h0, led}, 32'h0);
      rdx(32'hBFAF_F008, 32'h0);
      rdx(32'hBFAF_F008, 32'h1);
      rdx(32'hBFAF_F000, 32'h0);
      rdx(32'h0000_0040, 32'h12345678);
      rdx(32'h0000_0010, 32'hAA22BE44);

      // Read in flight during reset is discarded; switch sync restarts
      step(1'b0, 1'b1, 4'h0, 32'h0000_0040, 32'h0, 1'b0, 32'h0);
      chk("rst_rd_discard", rdata, 32'h0);
      rdx(32'hBFAF_F004, 32'h0);
      rdx(32'hBFAF_F004, 32'h0);
      rdx(32'hBFAF_F004, 32'h00000081);

      // Random traffic against the reference model
      for (int i = 0; i < 8; i++) wr(ram_addr(pool[i]), $urandom, 4'hF);
      for (int i = 0; i < 600; i++) begin
         int          op;
         logic [31:0] a;
         logic [31:0] d;
         op = $urandom_range(0, 9);
         if ($urandom_range(0, 15) == 0) sw_val = 8'($urandom);
         case (op)
            0, 1: wr(ram_addr(pool[$urandom_range(0, 7)]), $urandom, 4'($urandom_range(1, 15)));
            2, 3: rd(ram_addr(pool[$urandom_range(0, 7)]));
            4: begin
               a = {16'hBFAF, offs[$urandom_range(0, 6)]};
               d = (a[15:0] == 16'hF008 || a[15:0] == 16'hF00C) ? $urandom_range(0, 40) : $urandom;
               wr(a, d, 4'($urandom_range(1, 15)));
            end
            5, 6: rd({16'hBFAF, offs[$urandom_range(0, 6)]});
            7: idle();
            8: begin
               if ($urandom_range(0, 19) == 0)
                  step(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 32'h0);
               else
                  idle();
            end
            default: rd({16'hBFAF, 16'($urandom)});
         endcase
      end

      idle(); idle();
      chk("sb_drained", sb_q.size(), 32'h0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/sram_confreg_responder.md
Name: sram_confreg_responder

Overview:
- Responder side of the core's data SRAM interface: the core issues en/wen/addr/wdata and expects read data one cycle later.
- Decodes each access to either a local word-addressed RAM or a small configuration-register region.
- The config region holds LED outputs, synchronised switch inputs and a free-running timer with a compare interrupt.
- Sits outside the core, on the data_sram_* wires.

Parameters:
RAM_AW, 16, RAM word-address width; RAM holds 2^RAM_AW 32-bit words
CONF_BASE, 16'hBFAF, value of addr[31:16] that selects the config region

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous reset, active-low
data_sram_en  input  1  access valid this cycle
data_sram_wen  input  4  byte write enables; 0 = read, nonzero = write
data_sram_addr  input  32  byte address; bits [1:0] ignored
data_sram_wdata  input  32  write data, byte lane i = bits [8i+7:8i]
data_sram_rdata  output  32  read data, registered
led  output  16  LED register
switch  input  8  asynchronous switch inputs
timer_int  output  1  timer compare interrupt, level, sticky

Behaviour:
- Reset (rst=0 at a clock edge):
  - data_sram_rdata=0, led=0, timer=0, cmp=0, pending=0, timer_int=0, switch sync flops=0.
  - RAM contents are not reset.
- Decode:
  - conf = (addr[31:16]==CONF_BASE). Otherwise the access goes to the RAM word at addr[RAM_AW+1:2]; upper address bits are aliased.
- Read (en=1, wen=0):
  - data_sram_rdata is loaded at the edge ending the request cycle, so it is valid the following cycle.
  - The value holds until the next read.
- Write (en=1, wen!=0):
  - Only bytes with wen[i]=1 are updated, in RAM or in the config register.
  - data_sram_rdata is unchanged.
  - A read of the same address in the next cycle returns the new data (single port, no bypass needed).
- en=0: no state change apart from the timer and switch sync; rdata holds.
- Config offsets (addr[15:0]):
  - F000 LED: RW; bits [15:0] drive led; bits [31:16] read 0.
  - F004 SWITCH: RO; {24'b0, switch_sync}. switch_sync passes through a 2-flop synchroniser, so a change is visible to a read issued 2 cycles later.
  - F008 TIMER: RW; increments by 1 every cycle and wraps 0xFFFFFFFF->0. A write cycle loads the byte-merged value with no increment that cycle. The read value is the pre-edge counter.
  - F00C CMP: RW.
  - F010 STATUS: bit0 = pending, other bits read 0. Writing 1 to bit0 with wen[0]=1 clears pending; writing 0 has no effect.
  - Any other offset: reads 0, writes ignored.
- Interrupt:
  - pending sets at the edge after a cycle in which timer==cmp and cmp!=0.
  - Set and clear in the same cycle: set wins.
  - timer_int = pending (registered).
- Reset mid-operation: a read in flight is discarded and rdata=0; a write in the reset cycle does not update config registers. Whether RAM is written during reset does not matter; software must not rely on it.

Test Plan:
- Write 0xDEADBEEF to 0x00000010 with wen=4'hF, then read 0x00000010 -> rdata=0xDEADBEEF in the cycle after the read request.
- Write 0x11223344 with wen=4'b0101 over 0xDEADBEEF at the same address -> read returns 0xDE22BE44; wen=4'b1000 write of 0xAA000000 -> 0xAA22BE44.
- Write 0x0001A5A5 to 0xBFAFF000 -> led=16'hA5A5 next cycle; read returns 0x0000A5A5. switch=8'h3C -> read of 0xBFAFF004 issued ≥2 cycles later returns 0x0000003C.
- Write CMP=20, TIMER=10 -> timer_int rises 11 cycles after the TIMER write edge and stays high. Write 1 to STATUS -> timer_int=0 the next cycle. With cmp=0, timer never raises it.
- Write TIMER=0xFFFFFFFE -> reads show ...FE, FF, then 0x00000000 (wrap). Read of 0xBFAFF0FC -> 0; a write there changes nothing.
- Assert rst=0 for one cycle while rdata=0x12345678 and led=0xFFFF -> both 0 after the edge; timer restarts at 0; a RAM word written before reset still reads back unchanged.
